// File: rtl/el_ed_drv.sv
`default_nettype none
// ============================================================================
// Module      : el_ed_drv
// Description : Serial driver/decoder for an el_ed element. A word accepted
//               on the s_* handshake is shifted out one bit per clock on
//               ed_in (order set by LSB_FIRST) with ed_en high. Each cycle the
//               element output ed_out is sampled: it becomes the next
//               feedback bit ed_fb, and ed_out ^ ed_in is the decoded bit,
//               assembled in transmit order into rx_data. The decoded word
//               is held on rx_valid/rx_data until rx_ready.
// Ports       : clk      - sole clock, rising edge
//               rst      - asynchronous active-high reset
//               s_valid  / s_ready / s_data   - upstream word handshake
//               ed_en / ed_in / ed_fb         - drive to the el_ed element
//               ed_out                        - el_ed element output
//               rx_valid / rx_ready / rx_data - decoded word handshake
//               busy     - high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module el_ed_drv #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             ed_en,
    output logic             ed_in,
    output logic             ed_fb,
    input  logic             ed_out,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_rx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fb;
    logic             r_s_ready;
    logic             r_ed_en;
    logic             r_rx_valid;
    logic             r_busy;

    logic             w_ser_bit;
    logic             w_dec_bit;
    logic [WIDTH-1:0] w_sh_next;
    logic [WIDTH-1:0] w_rx_next;

    // The shift register is zero-filled as it drains, so after WIDTH shifts
    // (and after reset) it is all zeros; ed_in therefore reads 0 in IDLE and
    // DONE without any gating and comes straight from a register bit.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_ser_bit = r_sh[0];
            assign w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
            assign w_rx_next = {w_dec_bit, r_rx[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_ser_bit = r_sh[WIDTH-1];
            assign w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
            assign w_rx_next = {r_rx[WIDTH-2:0], w_dec_bit};
        end
    endgenerate

    assign w_dec_bit = ed_out ^ w_ser_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sh       <= '0;
            r_rx       <= '0;
            r_cnt      <= '0;
            r_fb       <= 1'b0;
            r_s_ready  <= 1'b1;
            r_ed_en    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_sh      <= s_data;
                        r_cnt     <= '0;
                        r_fb      <= 1'b0;
                        r_state   <= SHIFT;
                        r_s_ready <= 1'b0;
                        r_ed_en   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_fb  <= ed_out;
                    r_rx  <= w_rx_next;
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        r_state    <= DONE;
                        r_ed_en    <= 1'b0;
                        r_rx_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // s_valid is deliberately not looked at here; a new word
                    // waits until the decoded one has been taken.
                    if (rx_ready) begin
                        r_state    <= IDLE;
                        r_rx_valid <= 1'b0;
                        r_s_ready  <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_sh       <= '0;
                    r_cnt      <= '0;
                    r_s_ready  <= 1'b1;
                    r_ed_en    <= 1'b0;
                    r_rx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready  = r_s_ready;
    assign ed_en    = r_ed_en;
    assign ed_in    = w_ser_bit;
    assign ed_fb    = r_fb;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_el_ed_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_el_ed_drv
// Description : Self-checking bench for el_ed_drv. Two instances (LSB-first
//               and MSB-first) share all inputs; each has its own el_ed
//               model (ed_out = ed_fb while ed_en, or forced to 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_el_ed_drv;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       rx_ready;
    logic       force_one;

    logic       s_ready_l, ed_en_l, ed_in_l, ed_fb_l, ed_out_l, rx_valid_l, busy_l;
    logic [7:0] rx_data_l;
    logic       s_ready_m, ed_en_m, ed_in_m, ed_fb_m, ed_out_m, rx_valid_m, busy_m;
    logic [7:0] rx_data_m;

    int n_checks = 0;
    int n_errors = 0;

    assign ed_out_l = force_one ? 1'b1 : (ed_en_l ? ed_fb_l : 1'b0);
    assign ed_out_m = force_one ? 1'b1 : (ed_en_m ? ed_fb_m : 1'b0);

    el_ed_drv #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready_l),
        .s_data   (s_data),
        .ed_en    (ed_en_l),
        .ed_in    (ed_in_l),
        .ed_fb    (ed_fb_l),
        .ed_out   (ed_out_l),
        .rx_valid (rx_valid_l),
        .rx_ready (rx_ready),
        .rx_data  (rx_data_l),
        .busy     (busy_l)
    );

    el_ed_drv #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready_m),
        .s_data   (s_data),
        .ed_en    (ed_en_m),
        .ed_in    (ed_in_m),
        .ed_fb    (ed_fb_m),
        .ed_out   (ed_out_m),
        .rx_valid (rx_valid_m),
        .rx_ready (rx_ready),
        .rx_data  (rx_data_m),
        .busy     (busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the DUTs idle; returns at the negedge of the
    // first DONE cycle. Sequences are packed with step k in bit k.
    task automatic xfer(input logic [7:0] d, input logic [7:0] exp_rx,
                        input logic [7:0] exp_sl, input logic [7:0] exp_sm,
                        input logic [7:0] exp_fb);
        logic [7:0] sl, sm, fb;
        logic       en_ok, rv_ok;
        en_ok = 1'b1;
        rv_ok = 1'b1;
        check("idle_s_ready", {s_ready_l, s_ready_m}, 2'b11);
        s_valid  = 1'b1;
        s_data   = d;
        rx_ready = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = ~d;
        for (int k = 0; k < 8; k++) begin
            sl[k] = ed_in_l;
            sm[k] = ed_in_m;
            fb[k] = ed_fb_l;
            if (!ed_en_l || !ed_en_m || !busy_l || !busy_m || s_ready_l || s_ready_m)
                en_ok = 1'b0;
            if (rx_valid_l || rx_valid_m)
                rv_ok = 1'b0;
            @(negedge clk);
        end
        check("ed_in_seq_lsb", sl, exp_sl);
        check("ed_in_seq_msb", sm, exp_sm);
        check("ed_fb_seq", fb, exp_fb);
        check("shift_ctrl", en_ok, 1'b1);
        check("rx_valid_early", rv_ok, 1'b1);
        check("done_rx_valid", {rx_valid_l, rx_valid_m}, 2'b11);
        check("rx_data_lsb", rx_data_l, exp_rx);
        check("rx_data_msb", rx_data_m, exp_rx);
        check("done_ctrl", {s_ready_l, ed_en_l, ed_in_l, busy_l}, 4'b0001);
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        @(negedge clk);
        check("pop_rx_valid", rx_valid_l, 1'b0);
        check("pop_s_ready", {s_ready_l, busy_l}, 2'b10);
        rx_ready = 1'b0;
    endtask

    initial begin
        int         acc0, acc1, nrx;
        logic [7:0] rxw [2];
        logic       hold_ok;

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        rx_ready  = 1'b0;
        force_one = 1'b0;
        #3;
        check("rst_outputs", {s_ready_l, ed_en_l, ed_in_l, ed_fb_l, rx_valid_l, busy_l}, 6'b100000);
        check("rst_rx_data", rx_data_l, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Accepted on the very first edge after reset release.
        xfer(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00);
        pop();
        xfer(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00);
        pop();

        // Element stuck at 1: decoded bits are inverted, feedback 0 then 1s.
        force_one = 1'b1;
        xfer(8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'hFE);
        pop();
        force_one = 1'b0;

        // Back-pressure: decoded word held, new s_valid ignored.
        xfer(8'h55, 8'h55, 8'h55, 8'hAA, 8'h00);
        s_valid = 1'b1;
        s_data  = 8'h99;
        hold_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rx_data_l != 8'h55 || !rx_valid_l || s_ready_l || !busy_l) hold_ok = 1'b0;
        end
        check("hold_rx", hold_ok, 1'b1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("hold_release", {s_ready_l, rx_valid_l}, 2'b10);
        xfer(8'h99, 8'h99, 8'h99, 8'h99, 8'h00);
        pop();

        // Asynchronous reset in the middle of a word.
        force_one = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'hFF;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_fb", ed_fb_l, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {s_ready_l, ed_en_l, ed_in_l, ed_fb_l, rx_valid_l, busy_l}, 6'b100000);
        check("async_rst_rx_data", rx_data_l, 8'h00);
        force_one = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(8'h81, 8'h81, 8'h81, 8'h81, 8'h00);
        pop();

        // Back-to-back words with s_valid and rx_ready held high.
        acc0 = -1;
        acc1 = -1;
        nrx  = 0;
        rxw[0] = 8'h00;
        rxw[1] = 8'h00;
        s_data   = 8'h01;
        s_valid  = 1'b1;
        rx_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (acc0 >= 0 && acc0 == c - 1) s_data = 8'h02;
            if (acc1 >= 0 && acc1 == c - 1) s_valid = 1'b0;
            if (s_valid && s_ready_l) begin
                if (acc0 < 0) acc0 = c;
                else if (acc1 < 0) acc1 = c;
            end
            if (rx_valid_l && nrx < 2) begin
                rxw[nrx] = rx_data_l;
                nrx++;
            end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        s_valid  = 1'b0;
        check("b2b_gap", acc1 - acc0, 10);
        check("b2b_count", nrx, 2);
        check("b2b_word0", rxw[0], 8'h01);
        check("b2b_word1", rxw[1], 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
